// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter that shares one register access bus among several host adapters.
// Each transaction runs IDLE -> BUSY -> RESPOND, with an optional watchdog on the BUSY phase.
module rggen_register_access_arbiter #(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int TIMEOUT       = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [HOSTS-1:0]             i_host_valid,
    input  logic [2*HOSTS-1:0]           i_host_access,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
    input  logic [HOSTS*BUS_WIDTH-1:0]   i_host_write_data,
    input  logic [HOSTS*BUS_WIDTH-1:0]   i_host_strobe,
    output logic [HOSTS-1:0]             o_host_ready,
    output logic [2*HOSTS-1:0]           o_host_status,
    output logic [HOSTS*BUS_WIDTH-1:0]   o_host_read_data,
    output logic [HOSTS-1:0]             o_grant,
    output logic                         o_register_valid,
    output logic [1:0]                   o_register_access,
    output logic [ADDRESS_WIDTH-1:0]     o_register_address,
    output logic [BUS_WIDTH-1:0]         o_register_write_data,
    output logic [BUS_WIDTH-1:0]         o_register_strobe,
    input  logic                         i_register_ready,
    input  logic [1:0]                   i_register_status,
    input  logic [BUS_WIDTH-1:0]         i_register_read_data
);

    localparam int PTR_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TIMER_LAST     = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [1:0]       STATUS_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e                      state_r;
    logic [PTR_W-1:0]            ptr_r;
    logic [TMR_W-1:0]            timer_r;
    logic [HOSTS-1:0]            grant_r;
    logic                        reg_valid_r;
    logic [1:0]                  reg_access_r;
    logic [ADDRESS_WIDTH-1:0]    reg_address_r;
    logic [BUS_WIDTH-1:0]        reg_write_data_r;
    logic [BUS_WIDTH-1:0]        reg_strobe_r;
    logic [HOSTS-1:0]            host_ready_r;
    logic [2*HOSTS-1:0]          host_status_r;
    logic [HOSTS*BUS_WIDTH-1:0]  host_read_data_r;

    state_e                      state_next_s;
    logic [PTR_W-1:0]            ptr_next_s;
    logic [TMR_W-1:0]            timer_next_s;
    logic [HOSTS-1:0]            grant_next_s;
    logic                        reg_valid_next_s;
    logic [1:0]                  reg_access_next_s;
    logic [ADDRESS_WIDTH-1:0]    reg_address_next_s;
    logic [BUS_WIDTH-1:0]        reg_write_data_next_s;
    logic [BUS_WIDTH-1:0]        reg_strobe_next_s;
    logic [HOSTS-1:0]            host_ready_next_s;
    logic [2*HOSTS-1:0]          host_status_next_s;
    logic [HOSTS*BUS_WIDTH-1:0]  host_read_data_next_s;

    int                          rr_sum_s;
    logic [PTR_W-1:0]            rr_idx_s;
    logic                        rr_hit_s;
    logic                        pick_found_s;
    logic [PTR_W-1:0]            pick_idx_s;
    logic [PTR_W-1:0]            pick_next_ptr_s;
    logic [HOSTS-1:0]            pick_grant_s;
    logic [1:0]                  pick_access_s;
    logic [ADDRESS_WIDTH-1:0]    pick_address_s;
    logic [BUS_WIDTH-1:0]        pick_write_data_s;
    logic [BUS_WIDTH-1:0]        pick_strobe_s;

    logic                        timeout_hit_s;
    logic [1:0]                  resp_status_s;
    logic [BUS_WIDTH-1:0]        resp_data_s;
    logic [2*HOSTS-1:0]          route_status_s;
    logic [HOSTS*BUS_WIDTH-1:0]  route_data_s;

    // Round-robin search: first valid host at or after the pointer, wrapping at HOSTS-1.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        rr_sum_s     = '0;
        rr_idx_s     = '0;
        rr_hit_s     = 1'b0;
        for (int off = 0; off < HOSTS; off++) begin
            rr_sum_s     = int'(ptr_r) + off;
            rr_idx_s     = (rr_sum_s >= HOSTS) ? PTR_W'(rr_sum_s - HOSTS) : PTR_W'(rr_sum_s);
            rr_hit_s     = !pick_found_s && i_host_valid[rr_idx_s];
            pick_idx_s   = rr_hit_s ? rr_idx_s : pick_idx_s;
            pick_found_s = pick_found_s || rr_hit_s;
        end
        pick_next_ptr_s = (pick_idx_s == PTR_W'(HOSTS - 1)) ? '0 : (pick_idx_s + PTR_W'(1));
    end

    // Payload multiplexer for the picked host, plus its one-hot grant.
    always_comb begin
        pick_grant_s      = '0;
        pick_access_s     = 2'b00;
        pick_address_s    = '0;
        pick_write_data_s = '0;
        pick_strobe_s     = '0;
        for (int h = 0; h < HOSTS; h++) begin
            pick_grant_s[h]   = (pick_idx_s == PTR_W'(h));
            pick_access_s     = pick_grant_s[h] ? i_host_access[2*h +: 2] : pick_access_s;
            pick_address_s    = pick_grant_s[h] ? i_host_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH] : pick_address_s;
            pick_write_data_s = pick_grant_s[h] ? i_host_write_data[h*BUS_WIDTH +: BUS_WIDTH] : pick_write_data_s;
            pick_strobe_s     = pick_grant_s[h] ? i_host_strobe[h*BUS_WIDTH +: BUS_WIDTH] : pick_strobe_s;
        end
    end

    // Response selection; a real ready always beats the watchdog in the same cycle.
    always_comb begin
        timeout_hit_s  = (TIMEOUT > 0) && (timer_r == TIMER_LAST);
        resp_status_s  = i_register_ready ? i_register_status : STATUS_TIMEOUT;
        resp_data_s    = i_register_ready ? i_register_read_data : '0;
        route_status_s = '0;
        route_data_s   = '0;
        for (int h = 0; h < HOSTS; h++) begin
            route_status_s[2*h +: 2]             = grant_r[h] ? resp_status_s : 2'b00;
            route_data_s[h*BUS_WIDTH +: BUS_WIDTH] = grant_r[h] ? resp_data_s : '0;
        end
    end

    // Next-state and next-output logic; host response outputs default to 0 so the pulse lasts one cycle.
    always_comb begin
        state_next_s          = state_r;
        ptr_next_s            = ptr_r;
        timer_next_s          = timer_r;
        grant_next_s          = grant_r;
        reg_valid_next_s      = reg_valid_r;
        reg_access_next_s     = reg_access_r;
        reg_address_next_s    = reg_address_r;
        reg_write_data_next_s = reg_write_data_r;
        reg_strobe_next_s     = reg_strobe_r;
        host_ready_next_s     = '0;
        host_status_next_s    = '0;
        host_read_data_next_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_next_s          = ST_BUSY;
                    ptr_next_s            = pick_next_ptr_s;
                    timer_next_s          = '0;
                    grant_next_s          = pick_grant_s;
                    reg_valid_next_s      = 1'b1;
                    reg_access_next_s     = pick_access_s;
                    reg_address_next_s    = pick_address_s;
                    reg_write_data_next_s = pick_write_data_s;
                    reg_strobe_next_s     = pick_strobe_s;
                end else begin
                    grant_next_s     = '0;
                    reg_valid_next_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (i_register_ready || timeout_hit_s) begin
                    state_next_s          = ST_RESPOND;
                    reg_valid_next_s      = 1'b0;
                    host_ready_next_s     = grant_r;
                    host_status_next_s    = route_status_s;
                    host_read_data_next_s = route_data_s;
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            ST_RESPOND: begin
                state_next_s = ST_IDLE;
                grant_next_s = '0;
            end
            default: begin
                state_next_s     = ST_IDLE;
                grant_next_s     = '0;
                reg_valid_next_s = 1'b0;
                timer_next_s     = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r          <= ST_IDLE;
            ptr_r            <= '0;
            timer_r          <= '0;
            grant_r          <= '0;
            reg_valid_r      <= 1'b0;
            reg_access_r     <= 2'b00;
            reg_address_r    <= '0;
            reg_write_data_r <= '0;
            reg_strobe_r     <= '0;
            host_ready_r     <= '0;
            host_status_r    <= '0;
            host_read_data_r <= '0;
        end else begin
            state_r          <= state_next_s;
            ptr_r            <= ptr_next_s;
            timer_r          <= timer_next_s;
            grant_r          <= grant_next_s;
            reg_valid_r      <= reg_valid_next_s;
            reg_access_r     <= reg_access_next_s;
            reg_address_r    <= reg_address_next_s;
            reg_write_data_r <= reg_write_data_next_s;
            reg_strobe_r     <= reg_strobe_next_s;
            host_ready_r     <= host_ready_next_s;
            host_status_r    <= host_status_next_s;
            host_read_data_r <= host_read_data_next_s;
        end
    end

    assign o_host_ready          = host_ready_r;
    assign o_host_status         = host_status_r;
    assign o_host_read_data      = host_read_data_r;
    assign o_grant               = grant_r;
    assign o_register_valid      = reg_valid_r;
    assign o_register_access     = reg_access_r;
    assign o_register_address    = reg_address_r;
    assign o_register_write_data = reg_write_data_r;
    assign o_register_strobe     = reg_strobe_r;

endmodule
